// File: rtl/fifo_enq_arbiter.sv
// Two-requester round-robin arbiter in front of a shared downstream Fifo enq method.
// Optional grant counters are built when FIFO_ARB_COUNT_EN is defined.
module fifo_enq_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0__ENA,
  input  logic [WIDTH-1:0] req0_v,
  output logic             req0__RDY,
  input  logic             req1__ENA,
  input  logic [WIDTH-1:0] req1_v,
  output logic             req1__RDY,
  output logic             fifo_enq__ENA,
  output logic [WIDTH-1:0] fifo_enq_v,
  input  logic             fifo_enq__RDY,
  output logic             fifo_enq_src
`ifdef FIFO_ARB_COUNT_EN
  ,
  output logic [CNTW-1:0]  grant_cnt0,
  output logic [CNTW-1:0]  grant_cnt1
`endif
);

  logic             r_buf0_valid;
  logic             r_buf1_valid;
  logic [WIDTH-1:0] r_buf0_data;
  logic [WIDTH-1:0] r_buf1_data;
  logic             r_prio;

  logic             w_any;
  logic             w_sel;
  logic             w_grant;
  logic             w_load0;
  logic             w_load1;
  logic             w_clr0;
  logic             w_clr1;

  // Selection and grant decode; loads are gated by the buffer being empty.
  always_comb begin
    w_any = r_buf0_valid | r_buf1_valid;
    if (r_buf0_valid && r_buf1_valid) begin
      w_sel = r_prio;
    end else if (r_buf1_valid) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
    w_grant = w_any & fifo_enq__RDY;
    w_clr0  = w_grant & ~w_sel;
    w_clr1  = w_grant & w_sel;
    w_load0 = req0__ENA & ~r_buf0_valid;
    w_load1 = req1__ENA & ~r_buf1_valid;
  end

  assign req0__RDY     = ~r_buf0_valid;
  assign req1__RDY     = ~r_buf1_valid;
  assign fifo_enq__ENA = w_grant;

  // Payload mux; outputs are forced to zero while both buffers are empty.
  always_comb begin
    if (w_any) begin
      fifo_enq_src = w_sel;
      fifo_enq_v   = w_sel ? r_buf1_data : r_buf0_data;
    end else begin
      fifo_enq_src = 1'b0;
      fifo_enq_v   = '0;
    end
  end

  // Valid flags and round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_buf0_valid <= 1'b0;
      r_buf1_valid <= 1'b0;
      r_prio       <= 1'b0;
    end else begin
      if (w_load0) begin
        r_buf0_valid <= 1'b1;
      end else if (w_clr0) begin
        r_buf0_valid <= 1'b0;
      end
      if (w_load1) begin
        r_buf1_valid <= 1'b1;
      end else if (w_clr1) begin
        r_buf1_valid <= 1'b0;
      end
      if (w_grant) begin
        r_prio <= ~w_sel;
      end
    end
  end

  // Payload storage is qualified by the valid flags, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (w_load0) begin
      r_buf0_data <= req0_v;
    end
    if (w_load1) begin
      r_buf1_data <= req1_v;
    end
  end

`ifdef FIFO_ARB_COUNT_EN
  logic [CNTW-1:0] r_cnt0;
  logic [CNTW-1:0] r_cnt1;

  // Per-requester grant counters, wrapping naturally.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_clr0) begin
        r_cnt0 <= r_cnt0 + CNTW'(1);
      end
      if (w_clr1) begin
        r_cnt1 <= r_cnt1 + CNTW'(1);
      end
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Scoreboard bench for fifo_enq_arbiter: the driver predicts per-cycle status and grants
// from a buffer/round-robin model; a separate monitor pops and compares.
module tb_fifo_enq_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0__ENA, req1__ENA, fifo_enq__RDY;
  logic [31:0] req0_v, req1_v;
  logic        req0__RDY, req1__RDY, fifo_enq__ENA, fifo_enq_src;
  logic [31:0] fifo_enq_v;
`ifdef FIFO_ARB_COUNT_EN
  logic [3:0]  grant_cnt0, grant_cnt1;
`endif

  fifo_enq_arbiter #(.WIDTH(32), .CNTW(4)) dut (
    .CLK(CLK), .RST(RST),
    .req0__ENA(req0__ENA), .req0_v(req0_v), .req0__RDY(req0__RDY),
    .req1__ENA(req1__ENA), .req1_v(req1_v), .req1__RDY(req1__RDY),
    .fifo_enq__ENA(fifo_enq__ENA), .fifo_enq_v(fifo_enq_v),
    .fifo_enq__RDY(fifo_enq__RDY), .fifo_enq_src(fifo_enq_src)
`ifdef FIFO_ARB_COUNT_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        r0;
    logic        r1;
    logic        ena;
    logic        src;
    logic [31:0] v;
    logic [3:0]  c0;
    logic [3:0]  c1;
  } stat_t;

  typedef struct packed {
    logic        src;
    logic [31:0] v;
  } grant_t;

  stat_t  stq[$];
  grant_t gq[$];

  // Reference model: one slot per requester, round-robin pointer, grant counters.
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  logic        m_prio;
  logic [3:0]  m_cnt   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int mon_grants = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    n_acc = n_acc - int'(m_valid[0]) - int'(m_valid[1]);
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    m_prio = 1'b0;
    m_cnt[0] = 4'd0; m_cnt[1] = 4'd0;
  endtask

  // One clock cycle of stimulus plus prediction.
  task automatic cyc(input logic e0, input logic [31:0] d0, input logic e1,
                     input logic [31:0] d1, input logic rdy,
                     output logic a0, output logic a1);
    stat_t  st;
    grant_t g;
    logic   any, sel;
    @(negedge CLK);
    a0 = e0 & ~m_valid[0];
    a1 = e1 & ~m_valid[1];
    req0__ENA = a0; req0_v = d0;
    req1__ENA = a1; req1_v = d1;
    fifo_enq__RDY = rdy;
    #1;
    any = m_valid[0] | m_valid[1];
    if (m_valid[0] && m_valid[1]) sel = m_prio;
    else sel = m_valid[1];
    st.r0  = ~m_valid[0];
    st.r1  = ~m_valid[1];
    st.ena = any & rdy;
    st.src = any ? sel : 1'b0;
    st.v   = any ? m_data[sel] : 32'h0;
    st.c0  = m_cnt[0];
    st.c1  = m_cnt[1];
    stq.push_back(st);
    if (st.ena) begin
      g.src = sel; g.v = m_data[sel];
      gq.push_back(g);
      m_valid[sel] = 1'b0;
      m_prio = ~sel;
      m_cnt[sel] = m_cnt[sel] + 4'd1;
    end
    if (a0) begin m_valid[0] = 1'b1; m_data[0] = d0; n_acc++; end
    if (a1) begin m_valid[1] = 1'b1; m_data[1] = d1; n_acc++; end
  endtask

  task automatic idle(input int n, input logic rdy);
    logic x0, x1;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, rdy, x0, x1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs checked before the next rising edge.
  task automatic do_reset();
    @(negedge CLK);
    req0__ENA = 1'b0; req1__ENA = 1'b0; fifo_enq__RDY = 1'b0;
    #3;
    RST = 1'b1;
    fifo_enq__RDY = 1'b1;
    #1;
    chk("async_rst_rdy0", req0__RDY, 1);
    chk("async_rst_rdy1", req1__RDY, 1);
    chk("async_rst_ena", fifo_enq__ENA, 0);
    chk("async_rst_src", fifo_enq_src, 0);
    chk("async_rst_v", fifo_enq_v, 0);
    model_clear();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Monitor: compares each predicted cycle and each downstream grant.
  always begin
    stat_t  st;
    grant_t g;
    @(negedge CLK);
    #2;
    if (stq.size() > 0) begin
      st = stq.pop_front();
      chk("req0_rdy", req0__RDY, st.r0);
      chk("req1_rdy", req1__RDY, st.r1);
      chk("enq_ena", fifo_enq__ENA, st.ena);
      chk("enq_src", fifo_enq_src, st.src);
      chk("enq_v", fifo_enq_v, st.v);
`ifdef FIFO_ARB_COUNT_EN
      chk("grant_cnt0", grant_cnt0, st.c0);
      chk("grant_cnt1", grant_cnt1, st.c1);
`endif
    end
    if (fifo_enq__ENA === 1'b1) begin
      mon_grants++;
      if (gq.size() == 0) begin
        chk("unexpected_grant", fifo_enq__ENA, 0);
      end else begin
        g = gq.pop_front();
        chk("grant_src", fifo_enq_src, g.src);
        chk("grant_data", fifo_enq_v, g.v);
      end
    end
  end

  initial begin
    logic a0, a1, x0, x1;
    int   n0, n1, g0;
    RST = 1'b1;
    req0__ENA = 1'b0; req1__ENA = 1'b0; fifo_enq__RDY = 1'b1;
    req0_v = 32'h0; req1_v = 32'h0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    m_data[0] = 32'h0; m_data[1] = 32'h0;
    model_clear();
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_rdy0", req0__RDY, 1);
    chk("rst_rdy1", req1__RDY, 1);
    chk("rst_ena", fifo_enq__ENA, 0);
    chk("rst_src", fifo_enq_src, 0);
    chk("rst_v", fifo_enq_v, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Single enqueue, one-cycle forwarding latency.
    cyc(1'b1, 32'h11, 1'b0, 32'h0, 1'b1, x0, x1);
    idle(3, 1'b1);

`ifdef FIFO_ARB_COUNT_EN
    // Counter wrap: 2^4+3 grants to requester 1.
    do_reset();
    for (int i = 0; i < 38; i++) cyc(1'b0, 32'h0, 1'b1, 32'h300 + i, 1'b1, x0, x1);
    idle(1, 1'b1);
    #2;
    chk("cnt_wrap_cnt1", grant_cnt1, 3);
    chk("cnt_wrap_cnt0", grant_cnt0, 0);
`endif

    // Simultaneous enqueue with prio=0.
    do_reset();
    cyc(1'b1, 32'hA0, 1'b1, 32'hB1, 1'b1, x0, x1);
    idle(3, 1'b1);

    // Saturation: 8 payloads each, strict alternation expected.
    n0 = 0; n1 = 0;
    #2;
    g0 = mon_grants;
    for (int i = 0; i < 24; i++) begin
      cyc(n0 < 8, 32'h100 + n0, n1 < 8, 32'h200 + n1, 1'b1, a0, a1);
      if (a0) n0++;
      if (a1) n1++;
    end
    idle(2, 1'b1);
    #2;
    chk("sat_grants", mon_grants - g0, 16);

    // Backpressure for 10 cycles, then drain in two.
    cyc(1'b1, 32'hD0, 1'b1, 32'hD1, 1'b0, x0, x1);
    idle(10, 1'b0);
    #2;
    g0 = mon_grants;
    idle(2, 1'b1);
    #2;
    chk("drain_grants", mon_grants - g0, 2);
    idle(1, 1'b1);

    // Reset with both buffers full; nothing stale afterwards.
    cyc(1'b1, 32'hE0, 1'b1, 32'hE1, 1'b0, x0, x1);
    do_reset();
    idle(3, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
          ($urandom_range(0, 9) < 7), x0, x1);
    end
    idle(4, 1'b1);
    #2;
    chk("grant_queue_empty", gq.size(), 0);
    chk("forwarded_vs_accepted", mon_grants, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
